// File: rtl/text_pkg.sv
// Shared constants and types for the 40x15 text-mode character buffer.
package text_pkg;

  localparam int unsigned TEXT_COLS  = 40;
  localparam int unsigned TEXT_ROWS  = 15;
  localparam int unsigned TEXT_CELLS = 600;
  localparam int unsigned TILE_W     = 16;
  localparam int unsigned TILE_H     = 32;

  typedef logic [7:0] char_code_t;
  typedef logic [5:0] tile_x_t;
  typedef logic [3:0] tile_y_t;
  typedef logic [9:0] cell_addr_t;

  typedef enum logic {StIdle, StClear} sched_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the pointer flips to the other requester after every grant.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] valid_i,
  output logic [1:0] gnt_o
);

  // ptr_q == 0 favours requester 0 on a tie
  logic ptr_q, ptr_d;

  // Grant and next pointer
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (valid_i == 2'b11) begin
        gnt_o = ptr_q ? 2'b10 : 2'b01;
      end else begin
        gnt_o = valid_i;
      end
    end
    ptr_d = ptr_q;
    if (gnt_o[0]) begin
      ptr_d = 1'b1;
    end else if (gnt_o[1]) begin
      ptr_d = 1'b0;
    end
  end

  // Pointer register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/text_buffer_write_scheduler.sv
// Owns the character RAM write port: arbitrates two writers and runs a full-screen clear,
// optionally confining all writes to vertical blanking.
module text_buffer_write_scheduler
  import text_pkg::*;
#(
  parameter int unsigned COLS        = TEXT_COLS,
  parameter int unsigned ROWS        = TEXT_ROWS,
  parameter char_code_t  CLEAR_CHAR  = 8'd0,
  parameter bit          VBLANK_ONLY = 1'b1
) (
  input  logic       VGA_clk,
  input  logic       reset,
  input  logic       vblank,
  input  logic       clear_req,
  output logic       clear_busy,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [5:0] req0_x,
  input  logic [3:0] req0_y,
  input  logic [7:0] req0_char,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [5:0] req1_x,
  input  logic [3:0] req1_y,
  input  logic [7:0] req1_char,
  output logic       wr_en,
  output logic [9:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       range_err
);

  localparam cell_addr_t LastCell = cell_addr_t'(COLS * ROWS - 1);

  sched_state_e state_q, state_d;
  cell_addr_t   clr_cnt_q, clr_cnt_d;
  logic         clear_busy_q, clear_busy_d;
  logic         wr_en_q, wr_en_d;
  cell_addr_t   wr_addr_q, wr_addr_d;
  char_code_t   wr_data_q, wr_data_d;
  logic         range_err_q, range_err_d;

  logic       win;
  logic       arb_en;
  logic [1:0] gnt;
  logic       accept;
  tile_x_t    sel_x;
  tile_y_t    sel_y;
  char_code_t sel_char;
  logic       coord_oob;
  cell_addr_t lin_addr;

  assign win    = !VBLANK_ONLY || vblank;
  // A pending clear_req wins over both requesters in the same cycle
  assign arb_en = (state_q == StIdle) && win && !clear_req;

  rr_arbiter2 u_arb (
    .clk_i   (VGA_clk),
    .rst_i   (reset),
    .en_i    (arb_en),
    .valid_i ({req1_valid, req0_valid}),
    .gnt_o   (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign accept     = |gnt;

  // Select the granted requester's fields and form the linear cell address
  always_comb begin
    sel_x     = gnt[1] ? req1_x    : req0_x;
    sel_y     = gnt[1] ? req1_y    : req0_y;
    sel_char  = gnt[1] ? req1_char : req0_char;
    coord_oob = (32'(sel_x) >= COLS) || (32'(sel_y) >= ROWS);
    if (COLS == 40) begin
      // y*40 as y*32 + y*8 keeps the path multiplier-free
      lin_addr = (cell_addr_t'(sel_y) << 5) + (cell_addr_t'(sel_y) << 3) + cell_addr_t'(sel_x);
    end else begin
      lin_addr = cell_addr_t'(sel_y) * cell_addr_t'(COLS) + cell_addr_t'(sel_x);
    end
  end

  // Next state, clear counter and registered write-port values
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    range_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end else if (accept) begin
          if (coord_oob) begin
            // Accepted so the requester is never stalled, but nothing is written
            range_err_d = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = lin_addr;
            wr_data_d = sel_char;
          end
        end
      end
      StClear: begin
        // Outside the write window the counter holds and the clear resumes later
        if (win) begin
          wr_en_d   = 1'b1;
          wr_addr_d = clr_cnt_q;
          wr_data_d = CLEAR_CHAR;
          if (clr_cnt_q == LastCell) begin
            state_d   = StIdle;
            clr_cnt_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + cell_addr_t'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    clear_busy_d = (state_d == StClear);
  end

  // State and output registers
  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      clr_cnt_q    <= '0;
      clear_busy_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      range_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      clear_busy_q <= clear_busy_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      range_err_q  <= range_err_d;
    end
  end

  assign clear_busy = clear_busy_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign range_err  = range_err_q;

endmodule
